// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM register bank and its timebase.
package pwm_pkg;

    localparam int PWM_CNT_W   = 8;
    localparam int WR_FLAG_BIT = 7;
    localparam int REG_ADDR_W  = 7;

    localparam logic [REG_ADDR_W-1:0] ADDR_EN_LO   = 7'h00;
    localparam logic [REG_ADDR_W-1:0] ADDR_EN_HI   = 7'h01;
    localparam logic [REG_ADDR_W-1:0] ADDR_MODE_LO = 7'h02;
    localparam logic [REG_ADDR_W-1:0] ADDR_MODE_HI = 7'h03;
    localparam logic [REG_ADDR_W-1:0] ADDR_DUTY    = 7'h04;

    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = '1;

    // Full-scale duty holds the level high; otherwise high while the counter is below duty.
    function automatic logic pwm_compare(input logic [PWM_CNT_W-1:0] cnt,
                                         input logic [PWM_CNT_W-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Free-running PWM timebase: prescaler plus 8-bit period counter.
// period_wrap is high for the one cycle whose closing edge takes pwm_cnt from 255 to 0.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] pwm_cnt,
    output logic                 period_wrap
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc;
    logic        step;

    assign step        = (presc == PRE_LAST);
    assign period_wrap = step && (pwm_cnt == '1);

    // Prescaler wraps every PRESCALE cycles and advances the PWM counter on each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (step) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            presc   <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_reg_bank.sv
// PWM register bank: decodes SPI write frames into five control registers and
// drives 16 pins that are off, statically on, or follow the shared PWM level.
// Optional feature macro: PWM_DUTY_SHADOW_EN (duty updates deferred to period boundary).
module pwm_reg_bank
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 13,
    parameter int MAX_ADDR = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [7:0]  wr_cmd,
    input  logic [7:0]  wr_data,
    output logic [15:0] out,
    output logic        pwm_level
);

    localparam logic [REG_ADDR_W-1:0] MAX_ADDR_W = REG_ADDR_W'(MAX_ADDR);

    logic [PWM_CNT_W-1:0]  pwm_cnt;
    logic                  period_wrap;
    logic [15:0]           en_out;
    logic [15:0]           pwm_mode;
    logic [PWM_CNT_W-1:0]  duty_wr;
    logic [PWM_CNT_W-1:0]  duty_active;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic                  wr_accept;
    logic                  level_next;

    pwm_timebase #(
        .PRESCALE(PRESCALE)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_cnt    (pwm_cnt),
        .period_wrap(period_wrap)
    );

    assign wr_addr   = wr_cmd[REG_ADDR_W-1:0];
    assign wr_accept = wr_valid && wr_cmd[WR_FLAG_BIT] && (wr_addr <= MAX_ADDR_W);

    // Register file write port; reads and out-of-range addresses leave state untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out   <= '0;
            pwm_mode <= '0;
            duty_wr  <= '0;
        end else if (wr_accept) begin
            case (wr_addr)
                ADDR_EN_LO:   en_out[7:0]    <= wr_data;
                ADDR_EN_HI:   en_out[15:8]   <= wr_data;
                ADDR_MODE_LO: pwm_mode[7:0]  <= wr_data;
                ADDR_MODE_HI: pwm_mode[15:8] <= wr_data;
                ADDR_DUTY:    duty_wr        <= wr_data;
                default:      ;
            endcase
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    // duty_wr is the shadow; the compare value only changes at the 255->0 wrap,
    // so a write on the wrap edge itself is picked up one period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= '0;
        end else if (period_wrap) begin
            duty_active <= duty_wr;
        end
    end
`else
    // Duty register feeds the comparator directly.
    always_comb begin
        duty_active = duty_wr;
    end
`endif

    // Next-cycle PWM level from the current counter and active duty.
    always_comb begin
        level_next = pwm_compare(pwm_cnt, duty_active);
    end

    // Registered pin and level outputs; enabled pins follow the level only in PWM mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            pwm_level <= 1'b0;
        end else begin
            out       <= en_out & (~pwm_mode | {16{level_next}});
            pwm_level <= level_next;
        end
    end

endmodule

// File: tb/tb_pwm_reg_bank.sv
// Scoreboard bench for pwm_reg_bank: stimulus pushes per-cycle expectations from a
// behavioural model (time since reset -> counter value), a monitor pops and compares.
module tb_pwm_reg_bank;

    localparam int P      = 13;
    localparam int PERIOD = P * 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_cmd = '0;
    logic [7:0]  wr_data = '0;
    logic [15:0] out;
    logic        pwm_level;

    pwm_reg_bank #(
        .PRESCALE(P),
        .MAX_ADDR(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_cmd   (wr_cmd),
        .wr_data  (wr_data),
        .out      (out),
        .pwm_level(pwm_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] out;
        logic        lvl;
        int unsigned k;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   checking = 1'b0;

    logic [7:0]  m_reg[5];
    logic [7:0]  m_active;
    int unsigned m_k;

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        m_active = 8'h00;
        m_k      = 0;
    endtask

    // Expected outputs after the coming edge depend on the state before it.
    task automatic drive_and_push(input bit v, input logic [7:0] cmd, input logic [7:0] data);
        int unsigned cnt;
        logic [7:0]  duty;
        logic        lvl;
        exp_t        e;
        int          a;
        wr_valid = v;
        wr_cmd   = cmd;
        wr_data  = data;
        cnt = (m_k / P) % 256;
`ifdef PWM_DUTY_SHADOW_EN
        duty = m_active;
`else
        duty = m_reg[4];
`endif
        lvl = (duty == 8'hFF) || (cnt < int'(duty));
        for (int i = 0; i < 16; i++) begin
            logic en, md;
            en = (i < 8) ? m_reg[0][i] : m_reg[1][i-8];
            md = (i < 8) ? m_reg[2][i] : m_reg[3][i-8];
            e.out[i] = en && (md ? lvl : 1'b1);
        end
        e.lvl = lvl;
        e.k   = m_k + 1;
        sb.push_back(e);
`ifdef PWM_DUTY_SHADOW_EN
        if ((m_k + 1) % PERIOD == 0) m_active = m_reg[4];
`endif
        a = int'(cmd[6:0]);
        if (v && cmd[7] && a <= 4) m_reg[a] = data;
        m_k = m_k + 1;
    endtask

    task automatic step(input bit v, input logic [7:0] cmd, input logic [7:0] data);
        @(negedge clk);
        drive_and_push(v, cmd, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (out !== 16'h0000 || pwm_level !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got out=%h lvl=%b expected out=0000 lvl=0", tag, out, pwm_level);
        end
    endtask

    // Asynchronous reset placed mid-cycle, then released on a falling edge.
    task automatic mid_reset(input int hold);
        @(negedge clk);
        checking = 1'b0;
        wr_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        for (int i = 0; i < hold; i++) @(negedge clk);
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        model_reset();
        sb.delete();
        checking = 1'b1;
        drive_and_push(1'b0, 8'h00, 8'h00);
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 ns after the rising edge.
    always @(posedge clk) begin
        #1;
        if (checking) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: got no expectation, required one per cycle");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out !== e.out || pwm_level !== e.lvl) begin
                    n_fail++;
                    $display("FAIL out_cmp k=%0d: got out=%h lvl=%b expected out=%h lvl=%b",
                             e.k, out, pwm_level, e.out, e.lvl);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        model_reset();
        // Reset held, outputs must be cleared.
        repeat (3) @(negedge clk);
        check_reset_outputs("initial_reset");
        rst_n = 1'b1;
        checking = 1'b1;
        drive_and_push(1'b0, 8'h00, 8'h00);

        // Quiet for two periods: everything stays low.
        idle(2 * PERIOD);

        // All pins statically on.
        step(1'b1, 8'h80, 8'hFF);
        step(1'b1, 8'h81, 8'hFF);
        idle(8);

        // Four enabled pins, two modulated, duty one half.
        step(1'b1, 8'h80, 8'h0F);
        step(1'b1, 8'h81, 8'h00);
        step(1'b1, 8'h82, 8'h05);
        step(1'b1, 8'h83, 8'h00);
        step(1'b1, 8'h84, 8'h80);
        idle(2 * PERIOD);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step(1'b0, 8'h00, 8'h00);
            if (out[0]) highs++;
        end
        n_tests++;
        if (highs != 128 * P) begin
            n_fail++;
            $display("FAIL half_duty_high_time: got %0d expected %0d", highs, 128 * P);
        end

        // Duty extremes.
        step(1'b1, 8'h84, 8'h00);
        idle(2 * PERIOD);
        step(1'b1, 8'h84, 8'hFF);
        idle(2 * PERIOD);

        // Out-of-range write and read command, repeated writes.
        step(1'b1, 8'h85, 8'hAA);
        step(1'b1, 8'h02, 8'hAA);
        step(1'b1, 8'hFF, 8'h00);
        step(1'b1, 8'h83, 8'h0F);
        step(1'b1, 8'h83, 8'h0F);
        step(1'b1, 8'h81, 8'hF0);
        idle(16);

        // Duty change mid-period.
        step(1'b1, 8'h84, 8'h40);
        idle(PERIOD + PERIOD / 2);
        step(1'b1, 8'h84, 8'hC0);
        idle(2 * PERIOD);

        // Randomized writes with occasional mid-run resets.
        for (int i = 0; i < 9000; i++) begin
            if ($urandom_range(0, 2999) == 0) begin
                mid_reset(int'($urandom_range(1, 4)));
            end else if ($urandom_range(0, 29) == 0) begin
                logic [7:0] cmd;
                cmd = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) cmd[6:0] = 7'($urandom_range(0, 6));
                step(1'b1, cmd, 8'($urandom_range(0, 255)));
            end else begin
                step(1'b0, 8'h00, 8'h00);
            end
        end
        mid_reset(2);
        idle(20);

        @(posedge clk);
        #2 checking = 1'b0;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
